// File: rtl/dp_res_accumulator_pkg.sv
// Shared types and default sizes for the dot-product result accumulator.
package dp_package;

    // Default geometry of the dot-product datapath
    localparam int RRAM_DOTP_WIDTH     = 4;
    localparam int RESULTS_BUFFER_SIZE = 2;
    localparam int WORD_SIZE           = 16;
    localparam int ACC_WORD_SIZE       = 32;
    localparam int ACC_SLOTS_MAX       = 16;

    // Per-write accumulator operation; encoding 3 behaves as ACC_WRITE
    typedef enum logic [1:0] {
        ACC_WRITE = 2'd0,
        ACC_ADD   = 2'd1,
        ACC_MAX   = 2'd2
    } acc_op_t;

    // Drain FSM state, kept as plain constants for older tool flows
    typedef logic [1:0] state_acc_t;
    localparam state_acc_t ACC_IDLE  = 2'd0;
    localparam state_acc_t ACC_DRAIN = 2'd1;
    localparam state_acc_t ACC_DONE  = 2'd2;

    // Drain request bundle as seen by upstream control
    typedef struct packed {
        logic [$clog2(ACC_SLOTS_MAX)-1:0] drain_slot;
        logic                             drain_clear;
        logic                             drain_start;
    } ctrl_acc_t;

    // Status bundle reported back to control
    typedef struct packed {
        logic                     busy;
        logic                     drain_done;
        logic [ACC_SLOTS_MAX-1:0] sat;
    } flags_acc_t;

    // Index width that stays at least one bit for single-entry sizes
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_res_accumulator_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module dp_rr_arbiter
    import dp_package::*;
#(
    parameter int N = 2,
    localparam int PW = idx_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    logic [PW-1:0] ptr_reg;

    // Search requesters starting at the pointer, wrapping around once
    always_comb begin
        int cand;
        cand          = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_reg) + i) % N;
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = PW'(cand);
            end
        end
    end

    // Pointer moves past the granted engine; clear returns it to engine 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else if (clear_i) begin
            ptr_reg <= '0;
        end else if (grant_valid_o) begin
            ptr_reg <= (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/dp_res_accumulator.sv
// Multi-slot result accumulator: engines write/add/max into slots, a drain
// FSM streams one slot out lane by lane, optionally clearing it afterwards.
module dp_res_accumulator
    import dp_package::*;
#(
    parameter int NUM_DP    = 2,
    parameter int LANES     = RRAM_DOTP_WIDTH,
    parameter int SLOTS     = RESULTS_BUFFER_SIZE,
    parameter int RES_WIDTH = WORD_SIZE,
    parameter int ACC_WIDTH = ACC_WORD_SIZE,
    localparam int SW = idx_width(SLOTS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic [NUM_DP-1:0]                 in_valid_i,
    output logic [NUM_DP-1:0]                 in_ready_o,
    input  logic [NUM_DP*LANES*RES_WIDTH-1:0] in_data_i,
    input  logic [NUM_DP*SW-1:0]              in_slot_i,
    input  logic [NUM_DP*2-1:0]               in_op_i,
    input  logic                              drain_start_i,
    input  logic [SW-1:0]                     drain_slot_i,
    input  logic                              drain_clear_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [ACC_WIDTH-1:0]              out_data_o,
    output logic                              out_last_o,
    output logic                              busy_o,
    output logic                              drain_done_o,
    output logic [SLOTS-1:0]                  sat_o
);

    localparam int LW = idx_width(LANES);
    localparam int PW = idx_width(NUM_DP);
    localparam logic signed [ACC_WIDTH-1:0] ACC_POS_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_NEG_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_acc_t                  state_reg;
    logic [SW-1:0]               drain_slot_reg;
    logic                        drain_clear_reg;
    logic [LW-1:0]               lane_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg [SLOTS][LANES];
    logic [SLOTS-1:0]            sat_reg;

    logic [NUM_DP-1:0]           req;
    logic [NUM_DP-1:0]           grant;
    logic [PW-1:0]               grant_idx;
    logic                        grant_valid;
    logic [SW-1:0]               wr_slot;
    logic [1:0]                  wr_op;
    logic [LANES*ACC_WIDTH-1:0]  wr_val_flat;
    logic [LANES-1:0]            wr_sat;
    logic                        slot_locked;

    // The drained slot stays locked from the cycle after the start until IDLE,
    // so out_data_o cannot change under a stalled beat.
    assign slot_locked = (state_reg != ACC_IDLE);

    // Engines aimed at the locked slot, or arriving during a clear, do not compete
    for (genvar gi = 0; gi < NUM_DP; gi++) begin : g_req
        assign req[gi] = in_valid_i[gi] && !clear_i &&
                         !(slot_locked && (in_slot_i[gi*SW +: SW] == drain_slot_reg));
    end

    dp_rr_arbiter #(
        .N (NUM_DP)
    ) u_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .req_i         (req),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign in_ready_o = grant;
    assign wr_slot    = in_slot_i[int'(grant_idx)*SW +: SW];
    assign wr_op      = in_op_i[int'(grant_idx)*2 +: 2];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [RES_WIDTH-1:0] res;
        logic signed [ACC_WIDTH-1:0] ext;
        logic signed [ACC_WIDTH-1:0] cur;
        logic signed [ACC_WIDTH:0]   sum;
        logic signed [ACC_WIDTH-1:0] lane_val;
        logic                        lane_sat;

        assign res = in_data_i[(int'(grant_idx)*LANES + gi)*RES_WIDTH +: RES_WIDTH];
        assign ext = ACC_WIDTH'(res);
        assign cur = acc_reg[wr_slot][gi];
        // One extra bit of headroom exposes overflow as a sign-bit mismatch
        assign sum = (ACC_WIDTH+1)'(cur) + (ACC_WIDTH+1)'(ext);

        // Next value of this lane for the granted beat
        always_comb begin
            lane_val = ext;
            lane_sat = 1'b0;
            case (wr_op)
                ACC_ADD: begin
                    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                        lane_val = sum[ACC_WIDTH] ? ACC_NEG_MIN : ACC_POS_MAX;
                        lane_sat = 1'b1;
                    end else begin
                        lane_val = sum[ACC_WIDTH-1:0];
                    end
                end
                ACC_MAX: lane_val = (ext > cur) ? ext : cur;
                default: lane_val = ext;
            endcase
        end

        assign wr_val_flat[gi*ACC_WIDTH +: ACC_WIDTH] = lane_val;
        assign wr_sat[gi]                             = lane_sat;
    end

    // Accumulator storage and sticky saturation flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SLOTS; s++)
                for (int l = 0; l < LANES; l++)
                    acc_reg[s][l] <= '0;
            sat_reg <= '0;
        end else if (clear_i) begin
            for (int s = 0; s < SLOTS; s++)
                for (int l = 0; l < LANES; l++)
                    acc_reg[s][l] <= '0;
            sat_reg <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (state_reg == ACC_DONE && drain_clear_reg && drain_slot_reg == SW'(s)) begin
                    for (int l = 0; l < LANES; l++)
                        acc_reg[s][l] <= '0;
                    sat_reg[s] <= 1'b0;
                end else if (grant_valid && wr_slot == SW'(s)) begin
                    for (int l = 0; l < LANES; l++)
                        acc_reg[s][l] <= wr_val_flat[l*ACC_WIDTH +: ACC_WIDTH];
                    if (|wr_sat)
                        sat_reg[s] <= 1'b1;
                end
            end
        end
    end

    // Drain FSM: latch request, step lanes on handshake, one DONE cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= ACC_IDLE;
            drain_slot_reg  <= '0;
            drain_clear_reg <= 1'b0;
            lane_reg        <= '0;
        end else if (clear_i) begin
            state_reg       <= ACC_IDLE;
            drain_slot_reg  <= '0;
            drain_clear_reg <= 1'b0;
            lane_reg        <= '0;
        end else begin
            case (state_reg)
                ACC_IDLE: begin
                    if (drain_start_i) begin
                        state_reg       <= ACC_DRAIN;
                        drain_slot_reg  <= drain_slot_i;
                        drain_clear_reg <= drain_clear_i;
                        lane_reg        <= '0;
                    end
                end
                ACC_DRAIN: begin
                    if (out_ready_i) begin
                        if (lane_reg == LW'(LANES - 1))
                            state_reg <= ACC_DONE;
                        else
                            lane_reg <= lane_reg + 1'b1;
                    end
                end
                default: state_reg <= ACC_IDLE;
            endcase
        end
    end

    assign out_valid_o  = (state_reg == ACC_DRAIN);
    assign out_data_o   = out_valid_o ? acc_reg[drain_slot_reg][lane_reg] : '0;
    assign out_last_o   = out_valid_o && (lane_reg == LW'(LANES - 1));
    assign busy_o       = slot_locked;
    assign drain_done_o = (state_reg == ACC_DONE);
    assign sat_o        = sat_reg;

endmodule
